// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin time-shared pattern detector over NCH serial channels
// Ports: clk, rst (asynchronous, active-low); en (1 = RUN, 0 = IDLE);
//   cfg_we/cfg_pattern load the pattern in IDLE, cfg_err pulses on a write attempted in RUN;
//   req/bit_in per-channel serial requests, gnt one-hot combinational grant;
//   det_pulse/det_ch registered match report; clr_cnt/rd_ch/rd_cnt counter clear and readout;
//   state (0 = IDLE, 1 = RUN).
// Optional: define SEQ_DET_IRQ_EN to add parameter THRESH and sticky output irq.
module seq_det_arbiter #(
    parameter int NCH = 4,
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
`ifdef SEQ_DET_IRQ_EN
    , parameter int THRESH = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pattern,
    output logic                     cfg_err,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           bit_in,
    output logic [NCH-1:0]           gnt,
    output logic                     det_pulse,
    output logic [$clog2(NCH)-1:0]   det_ch,
    input  logic [NCH-1:0]           clr_cnt,
    input  logic [$clog2(NCH)-1:0]   rd_ch,
    output logic [CNT_W-1:0]         rd_cnt,
    output logic                     state
`ifdef SEQ_DET_IRQ_EN
    , output logic                   irq
`endif
);
    localparam int CW = $clog2(NCH);
    localparam int FW = $clog2(PAT_W + 1);
    // Reset pattern is alternating 1010... taken from the MSB end.
    localparam logic [2*PAT_W-1:0] ALT = {PAT_W{2'b10}};
    localparam logic [PAT_W-1:0] PAT_RST = ALT[2*PAT_W-1 -: PAT_W];

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] hist_q [NCH];
    logic [PAT_W-1:0] hist_d [NCH];
    logic [FW-1:0]    fill_q [NCH];
    logic [FW-1:0]    fill_d [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CW-1:0]    rr_q, rr_d, det_ch_q, det_ch_d, g_idx;
    logic [CW:0]      s;
    logic             det_q, det_d, err_q, err_d, g_any, gv, match;
    logic [PAT_W-1:0] new_hist;
    logic [FW-1:0]    new_fill;
    logic [NCH-1:0]   inc;

    // Scan from the highest offset down so the first requester after rr_q wins.
    always_comb begin
        g_any = 1'b0;
        g_idx = '0;
        s = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            s = {1'b0, rr_q} + (CW+1)'(i);
            s = (s >= (CW+1)'(NCH)) ? s - (CW+1)'(NCH) : s;
            if (req[s[CW-1:0]]) begin
                g_any = 1'b1;
                g_idx = s[CW-1:0];
            end
        end
    end

    always_comb begin
        gv = g_any && state_q == RUN;
        gnt = gv ? NCH'(1) << g_idx : '0;
        new_hist = {hist_q[g_idx][PAT_W-2:0], bit_in[g_idx]};
        new_fill = fill_q[g_idx] + FW'(fill_q[g_idx] != FW'(PAT_W));
        match = gv && new_fill == FW'(PAT_W) && new_hist == pat_q;
        state_d = en ? RUN : IDLE;
        pat_d = (cfg_we && state_q == IDLE) ? cfg_pattern : pat_q;
        err_d = cfg_we && state_q == RUN;
        rr_d = !gv ? rr_q : (g_idx == CW'(NCH - 1)) ? '0 : g_idx + 1'b1;
        det_d = match;
        det_ch_d = match ? g_idx : det_ch_q;
        for (int k = 0; k < NCH; k++) begin
            hist_d[k] = (state_q == IDLE && en) ? '0 : (gv && g_idx == CW'(k)) ? new_hist : hist_q[k];
            fill_d[k] = (state_q == IDLE && en) ? '0 : (gv && g_idx == CW'(k)) ? new_fill : fill_q[k];
            inc[k] = match && g_idx == CW'(k) && cnt_q[k] != '1;
            cnt_d[k] = clr_cnt[k] ? '0 : inc[k] ? cnt_q[k] + 1'b1 : cnt_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pat_q    <= PAT_RST;
            rr_q     <= '0;
            det_q    <= 1'b0;
            det_ch_q <= '0;
            err_q    <= 1'b0;
            hist_q   <= '{default: '0};
            fill_q   <= '{default: '0};
            cnt_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            rr_q     <= rr_d;
            det_q    <= det_d;
            det_ch_q <= det_ch_d;
            err_q    <= err_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
        end
    end

    assign state     = state_q;
    assign det_pulse = det_q;
    assign det_ch    = det_ch_q;
    assign cfg_err   = err_q;
    assign rd_cnt    = cnt_q[rd_ch];

`ifdef SEQ_DET_IRQ_EN
    logic [NCH-1:0] irq_q, irq_d;

    // Per-channel sticky flag; a clear on the same cycle as the crossing wins.
    always_comb begin
        for (int k = 0; k < NCH; k++)
            irq_d[k] = !clr_cnt[k] && (irq_q[k] || (inc[k] && cnt_q[k] + 1'b1 == CNT_W'(THRESH)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            irq_q <= '0;
        else
            irq_q <= irq_d;
    end

    assign irq = |irq_q;
`endif
endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb_seq_det_arbiter: directed stimulus against a bit-list model of the shared detector
module tb_seq_det_arbiter;
    localparam int NCH = 4;
    localparam int PAT_W = 3;
    localparam int CNT_W = 2;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, cfg_we = 1'b0, cfg_err, det_pulse, state;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [NCH-1:0] req = '0, bit_in = '0, gnt, clr_cnt = '0;
    logic [1:0] det_ch, rd_ch = '0;
    logic [CNT_W-1:0] rd_cnt;

    seq_det_arbiter #(.NCH(NCH), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_err(cfg_err), .req(req), .bit_in(bit_in), .gnt(gnt), .det_pulse(det_pulse),
        .det_ch(det_ch), .clr_cnt(clr_cnt), .rd_ch(rd_ch), .rd_cnt(rd_cnt), .state(state));

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0, npulse = 0, last_ch = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: each channel keeps the plain list of bits it has been granted since the
    // last IDLE->RUN; a match is "at least PAT_W bits and the newest PAT_W equal the pattern".
    int m_run, m_rr, m_det, m_dch, m_err;
    int m_cnt [NCH];
    int m_len [NCH];
    bit m_bits [NCH][256];
    logic [PAT_W-1:0] m_pat;

    function automatic int pick();
        if (m_run == 0) return -1;
        for (int i = 0; i < NCH; i++)
            if (req[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int g, hit;
        if (!rst) begin
            m_run = 0; m_rr = 0; m_det = 0; m_dch = 0; m_err = 0; m_pat = 3'b101;
            for (int k = 0; k < NCH; k++) begin m_cnt[k] = 0; m_len[k] = 0; end
        end else begin
            g = pick();
            hit = 0;
            if (g >= 0) begin
                m_bits[g][m_len[g]] = bit_in[g];
                m_len[g]++;
                if (m_len[g] >= PAT_W) begin
                    hit = 1;
                    for (int j = 0; j < PAT_W; j++)
                        if (m_bits[g][m_len[g] - PAT_W + j] != m_pat[PAT_W-1-j]) hit = 0;
                end
                m_rr = (g + 1) % NCH;
            end
            for (int k = 0; k < NCH; k++)
                if (clr_cnt[k]) m_cnt[k] = 0;
                else if (hit == 1 && k == g && m_cnt[k] < MAXC) m_cnt[k]++;
            m_det = hit;
            if (hit == 1) m_dch = g;
            m_err = (cfg_we && m_run == 1) ? 1 : 0;
            if (cfg_we && m_run == 0) m_pat = cfg_pattern;
            if (m_run == 0 && en) begin
                m_run = 1;
                for (int k = 0; k < NCH; k++) m_len[k] = 0;
            end else if (m_run == 1 && !en) m_run = 0;
        end
    end

    always @(negedge clk) begin
        int g;
        g = pick();
        chk("gnt", int'(gnt), g < 0 ? 0 : (1 << g));
        chk("state", int'(state), m_run);
        chk("det_pulse", int'(det_pulse), m_det);
        if (m_det == 1) chk("det_ch", int'(det_ch), m_dch);
        chk("cfg_err", int'(cfg_err), m_err);
        chk("rd_cnt", int'(rd_cnt), m_cnt[rd_ch]);
        if (det_pulse) begin npulse++; last_ch = det_ch; end
    end

    int fb [NCH][16];
    int fn [NCH];
    int fp [NCH];

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load(input int ch, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) fb[ch][i] = v[n-1-i];
        fn[ch] = n;
        fp[ch] = 0;
    endtask

    // Each loaded channel holds its next bit on req/bit_in until it is granted.
    task automatic feed();
        int budget;
        bit busy;
        budget = 200;
        busy = 1;
        while (busy && budget > 0) begin
            busy = 0;
            for (int c = 0; c < NCH; c++) begin
                req[c] = fp[c] < fn[c];
                bit_in[c] = (fp[c] < fn[c]) ? fb[c][fp[c]][0] : 1'b0;
                if (fp[c] < fn[c]) busy = 1;
            end
            if (busy) begin
                @(negedge clk);
                for (int c = 0; c < NCH; c++) if (gnt[c]) fp[c]++;
                step(1);
                budget--;
            end
        end
        req = '0;
        bit_in = '0;
        for (int c = 0; c < NCH; c++) fn[c] = 0;
        if (budget == 0) chk("feed_budget", 0, 1);
    endtask

    task automatic rdchk(input string name, input int ch, input int exp);
        rd_ch = 2'(ch);
        #1;
        chk(name, int'(rd_cnt), exp);
    endtask

    initial begin
        int p0;
        for (int c = 0; c < NCH; c++) fn[c] = 0;
        #10;
        for (int c = 0; c < NCH; c++) rdchk("reset_cnt", c, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_gnt", int'(gnt), 0);
        #7 rst = 1'b1;
        @(posedge clk); #1;

        en = 1'b1;
        step(1);
        req = 4'b1111;
        bit_in = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            #1 chk("fair_gnt", int'(gnt), 1 << (i % 4));
            step(1);
        end
        req = '0;
        bit_in = '0;
        en = 1'b0; step(1); en = 1'b1; step(1);

        p0 = npulse;
        load(0, 16'b10101, 5);
        feed();
        step(2);
        chk("single_pulses", npulse - p0, 2);
        chk("single_ch", last_ch, 0);
        rdchk("single_cnt0", 0, 2);

        en = 1'b0; step(1); en = 1'b1; step(1);
        p0 = npulse;
        load(1, 16'b101, 3);
        load(2, 16'b000, 3);
        feed();
        step(2);
        chk("inter_pulses", npulse - p0, 1);
        chk("inter_ch", last_ch, 1);
        rdchk("inter_cnt1", 1, 1);
        rdchk("inter_cnt2", 2, 0);

        en = 1'b0; step(1);
        cfg_pattern = 3'b110; cfg_we = 1'b1; step(1); cfg_we = 1'b0;
        en = 1'b1; step(1);
        p0 = npulse;
        load(0, 16'b110, 3);
        feed();
        step(2);
        chk("cfg_pulses", npulse - p0, 1);
        rdchk("cfg_cnt0", 0, 3);

        cfg_pattern = 3'b011; cfg_we = 1'b1; step(1); cfg_we = 1'b0;
        #1 chk("cfg_err_hi", int'(cfg_err), 1);
        step(1);
        chk("cfg_err_lo", int'(cfg_err), 0);
        p0 = npulse;
        load(0, 16'b110, 3);
        feed();
        step(2);
        chk("cfg_kept_pulses", npulse - p0, 1);
        rdchk("cfg_sat_cnt0", 0, 3);

        p0 = npulse;
        load(3, 16'b110110110110110, 15);
        feed();
        step(2);
        chk("sat_pulses", npulse - p0, 5);
        rdchk("sat_cnt3", 3, 3);

        load(3, 16'b11, 2);
        feed();
        req = 4'b1000; bit_in = 4'b0000; clr_cnt = 4'b1000;
        step(1);
        req = '0; clr_cnt = '0;
        #1 chk("clr_det", int'(det_pulse), 1);
        rdchk("clr_cnt3", 3, 0);
        step(1);

        load(0, 16'b10, 2);
        feed();
        #2 rst = 1'b0;
        #1 chk("arst_state", int'(state), 0);
        chk("arst_det", int'(det_pulse), 0);
        rdchk("arst_cnt1", 1, 0);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        p0 = npulse;
        load(0, 16'b101, 3);
        feed();
        step(2);
        chk("arst_pat_pulses", npulse - p0, 1);
        rdchk("arst_cnt0", 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
- Shares one programmable pattern-match datapath among NCH serial bit requesters; round-robin picks one channel per cycle.
- Keeps a per-channel history shift register, so each channel is matched independently while the comparator is time-shared.
- Per-channel saturating match counters, readable through a select port.
- Sits between the serial sources and the status/readout logic; replaces per-channel copies of the single-stream sequence detector.

Parameters:
- NCH, 4, number of requesting serial channels (2..8).
- PAT_W, 3, pattern length in bits. Default pattern 3'b101.
- CNT_W, 8, width of each per-channel match counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset; all state cleared while low.
- en  input  1  1 = run detection, 0 = idle/configure.
- cfg_we  input  1  pattern write strobe, honoured only in IDLE.
- cfg_pattern  input  PAT_W  pattern to load; MSB is the oldest bit.
- cfg_err  output  1  one-cycle pulse when cfg_we arrives outside IDLE.
- req  input  NCH  per-channel "bit valid" request.
- bit_in  input  NCH  per-channel serial data bit, sampled when granted.
- gnt  output  NCH  one-hot grant, combinational from req and rr_ptr.
- det_pulse  output  1  registered one-cycle match indication.
- det_ch  output  clog2(NCH)  channel that matched; valid with det_pulse.
- clr_cnt  input  NCH  synchronous clear of the selected channel counters.
- rd_ch  input  clog2(NCH)  counter read select.
- rd_cnt  output  CNT_W  combinational value of counter[rd_ch].
- state  output  1  0 = IDLE, 1 = RUN.

Behaviour:
- Reset values:
  - state = IDLE, pattern = 3'b101 (PAT_W'b1010... truncated for other widths).
  - All histories, fill counts and counters = 0; rr_ptr = 0.
  - gnt = 0, det_pulse = 0, det_ch = 0, cfg_err = 0.
- FSM:
  - IDLE -> RUN when en = 1. On this transition, clear every channel's history and fill count; counters are kept.
  - RUN -> IDLE when en = 0. Histories are frozen; counters are kept.
  - In IDLE: gnt = 0 and no detection occurs.
- Configuration:
  - cfg_we in IDLE loads cfg_pattern at the clock edge.
  - cfg_we in RUN is ignored, and cfg_err pulses high in the next cycle.
- Arbitration (RUN only):
  - Search order starts at rr_ptr; grant the first channel with req set.
  - After a grant to channel k, rr_ptr = (k+1) mod NCH.
  - No req: gnt = 0 and rr_ptr is unchanged.
  - Exactly one grant per cycle; an ungranted requester must hold req/bit_in (it is not queued).
- Datapath, on a grant to channel k:
  - hist[k] = {hist[k][PAT_W-2:0], bit_in[k]}.
  - fill[k] increments, saturating at PAT_W.
  - The match is computed on the new history: fill reaches PAT_W and new hist == pattern.
  - On a match: det_pulse = 1 and det_ch = k in the next cycle (latency 1), and counter[k] increments.
  - Overlapping matches count. With pattern 101, the stream 10101 gives 2 matches.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt[k] together with an increment of counter k in the same cycle: clear wins, result 0.
- Reset asserted mid-stream: everything returns to reset values immediately (asynchronous), including the pattern.

Optional Feature:
- Macro: SEQ_DET_IRQ_EN.
- Defined:
  - Adds parameter THRESH (default 4) and output irq (1 bit).
  - irq is set the cycle after any counter increments to THRESH.
  - irq stays set until a clr_cnt is applied to that channel or reset.
- Undefined: no irq port, no THRESH parameter, no threshold logic.

Test Plan:
- Reset, then read the counters: rst low 20 ns, release, rd_ch = 0..3 -> rd_cnt = 0 for every channel; state = 0; gnt = 0.
- Single channel: en = 1, req = 4'b0001, bit_in[0] = 1,0,1,0,1 on consecutive cycles -> det_pulse 1 cycle after the 3rd and 5th bits; det_ch = 0; counter[0] = 2.
- Fairness: req = 4'b1111 held 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, repeated; no channel's history is disturbed by another channel's bits.
- Interleaved channels:
  - Stimulus: ch1 and ch2 both request, ch1 feeds 1,0,1 and ch2 feeds 0,0,0, holding each bit until granted.
  - Expected: exactly one det_pulse with det_ch = 1; counter[1] = 1, counter[2] = 0.
- Configuration:
  - In IDLE, cfg_we with pattern 3'b110, then ch0 feeds 1,1,0 -> match.
  - cfg_we while in RUN -> cfg_err pulses one cycle and the pattern is unchanged.
- Saturation and clear:
  - CNT_W = 2, drive 5 matches on ch3 -> counter[3] = 3.
  - clr_cnt[3] in the same cycle as a match -> counter[3] = 0.
